// File: rtl/ram_stream_reader_pkg.sv
// Shared sizing, FIFO depth and FSM encoding for the RAM-to-stream reader.
`ifndef ADDR_SIZE
`define ADDR_SIZE 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef MEM_LENGTH
`define MEM_LENGTH 24
`endif

package ram_stream_reader_pkg;
  localparam int ADDR_SIZE  = `ADDR_SIZE;
  localparam int DATA_WIDTH = `DATA_WIDTH;
  localparam int MEM_LENGTH = `MEM_LENGTH;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/stream_fifo2.sv
// Two-entry skid FIFO holding RAM returns until the stream sink accepts them.
module stream_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count,
  output logic             empty,
  output logic             full
);
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the head is gated by empty at the top level.
  always_ff @(posedge clka) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ram_stream_reader.sv
// Reads len consecutive words (wrapping at MEM_LENGTH) from a single-port RAM
// and streams them out with valid/ready, throttling reads to the FIFO space.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int ADDR_SIZE  = `ADDR_SIZE,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int MEM_LENGTH = `MEM_LENGTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clka,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_SIZE-1:0]  base_addr,
  input  logic [ADDR_SIZE:0]    len,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_SIZE-1:0]  ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  input  logic [DATA_WIDTH-1:0] ram_douta,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);
  localparam logic [2:0]           DEPTH     = 3'(FIFO_DEPTH);
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_LENGTH - 1);
  localparam logic [ADDR_SIZE:0]   ONE_LEFT  = (ADDR_SIZE + 1)'(1);

  state_t                state;
  state_t                state_next;
  logic [ADDR_SIZE-1:0]  addr;
  logic [ADDR_SIZE:0]    remaining;
  logic                  issue;
  logic                  vld_p1;
  logic                  last_p1;
  logic                  done_q;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH:0]   fifo_dout;
  logic [2:0]            occupancy;
  logic                  head_last;

  // Words already owned by the FIFO after this cycle: stored + inflight - leaving.
  assign fifo_pop  = !fifo_empty && m_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, vld_p1} - {2'b00, fifo_pop};
  assign head_last = fifo_dout[DATA_WIDTH];

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE:  if (start && (len != '0)) state_next = RUN;
      RUN: begin
        issue = (occupancy < DEPTH) && !(fifo_full && !fifo_pop);
        if (issue && (remaining == ONE_LEFT)) state_next = DRAIN;
      end
      DRAIN: if (fifo_pop && head_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage p0 -> p1: read issued this cycle, its data arrives next cycle.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state   <= state_next;
      vld_p1  <= issue;
      last_p1 <= issue && (remaining == ONE_LEFT);
      done_q  <= ((state == IDLE) && start && (len == '0)) ||
                 ((state == DRAIN) && fifo_pop && head_last);
      if ((state == IDLE) && start) begin
        addr      <= base_addr;
        remaining <= len;
      end else if (issue) begin
        addr      <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  stream_fifo2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clka  (clka),
    .rst_n (rst_n),
    .push  (vld_p1),
    .din   ({last_p1, ram_douta}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign ram_ena   = issue;
  assign ram_wea   = 1'b0;
  assign ram_addra = addr;
  assign ram_dina  = '0;
  assign m_valid   = !fifo_empty;
  assign m_data    = fifo_empty ? '0 : fifo_dout[DATA_WIDTH-1:0];
  assign m_last    = !fifo_empty && head_last;
endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: transaction-level scoreboard plus directed timing pins.
module tb_ram_stream_reader;
  import ram_stream_reader_pkg::*;

  localparam int AW = ADDR_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int ML = MEM_LENGTH;

  logic          clka = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, ram_ena, ram_wea, m_valid, m_last;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dina, m_data;
  logic [DW-1:0] ram_douta = '0;
  logic          m_ready = 1'b0;

  ram_stream_reader dut (
    .clka(clka), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_ena(ram_ena), .ram_wea(ram_wea),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_douta(ram_douta),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clka = ~clka;

  logic [DW-1:0] mem [ML];
  initial for (int i = 0; i < ML; i++) mem[i] = DW'(i);
  always @(posedge clka) if (ram_ena) ram_douta <= mem[ram_addra];

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sink readiness: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
  int ready_mode = 0;
  int ready_phase = 0;
  always @(posedge clka) begin
    #1;
    case (ready_mode)
      0: m_ready = 1'b1;
      1: begin m_ready = (ready_phase % 3 == 0); ready_phase++; end
      default: m_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Behavioural model: expected words/addresses per accepted transfer, FIFO occupancy by counting.
  typedef struct { logic [DW-1:0] data; logic last; } word_t;
  word_t         exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            occ = 0;
  bit            ena_prev = 0, m_busy = 0, pend_done = 0, hold_prev = 0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  bit            exp_done, busy_next;
  word_t         w;
  int            a;

  int            hs_cyc[$], ena_cyc[$], done_cyc[$];
  logic [DW-1:0] hs_data[$];
  bit            hs_last[$];
  logic [AW-1:0] ena_addr[$];

  always @(negedge clka) begin
    if (!rst_n) begin
      check("rst_busy", busy, 0);       check("rst_done", done, 0);
      check("rst_ram_ena", ram_ena, 0); check("rst_m_valid", m_valid, 0);
      check("rst_m_last", m_last, 0);   check("rst_m_data", m_data, 0);
      check("rst_ram_addra", ram_addra, 0);
      exp_q.delete(); addr_q.delete();
      occ = 0; ena_prev = 0; m_busy = 0; pend_done = 0; hold_prev = 0;
    end else begin
      exp_done = pend_done; pend_done = 0; busy_next = m_busy;
      check("busy", busy, m_busy);
      check("done", done, exp_done);
      if (done) done_cyc.push_back(cyc);
      check("ram_wea", ram_wea, 0);
      check("ram_dina", ram_dina, 0);
      check("m_valid", m_valid, occ > 0);
      check("fifo_bound", occ <= 2, 1);
      if (hold_prev) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
        check("hold_last", m_last, prev_last);
      end
      if (ram_ena) begin
        ena_cyc.push_back(cyc); ena_addr.push_back(ram_addra);
        check("read_expected", addr_q.size() > 0, 1);
        if (addr_q.size() > 0) check("ram_addra", ram_addra, addr_q.pop_front());
      end
      if (m_valid && m_ready) begin
        hs_cyc.push_back(cyc); hs_data.push_back(m_data); hs_last.push_back(m_last);
        check("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("m_data", m_data, w.data);
          check("m_last", m_last, w.last);
          if (w.last) begin busy_next = 0; pend_done = 1; end
        end
      end
      if (start && !m_busy) begin
        if (len == 0) pend_done = 1;
        else begin
          busy_next = 1;
          a = int'(base_addr);
          for (int k = 0; k < int'(len); k++) begin
            addr_q.push_back(AW'(a));
            exp_q.push_back('{data: mem[a], last: (k == int'(len) - 1)});
            a = (a == ML - 1) ? 0 : a + 1;
          end
        end
      end
      hold_prev = m_valid && !m_ready; prev_data = m_data; prev_last = m_last;
      occ = occ + int'(ena_prev) - int'(m_valid && m_ready);
      ena_prev = ram_ena;
      m_busy = busy_next;
    end
  end

  function automatic int hc(int i);  return (i < hs_cyc.size())   ? hs_cyc[i]        : -1; endfunction
  function automatic int hd(int i);  return (i < hs_data.size())  ? int'(hs_data[i]) : -1; endfunction
  function automatic int hl(int i);  return (i < hs_last.size())  ? int'(hs_last[i]) : -1; endfunction
  function automatic int ec(int i);  return (i < ena_cyc.size())  ? ena_cyc[i]       : -1; endfunction
  function automatic int ea(int i);  return (i < ena_addr.size()) ? int'(ena_addr[i]) : -1; endfunction
  function automatic int dc(int i);  return (i < done_cyc.size()) ? done_cyc[i]      : -1; endfunction

  task automatic clear_logs();
    hs_cyc.delete(); hs_data.delete(); hs_last.delete();
    ena_cyc.delete(); ena_addr.delete(); done_cyc.delete();
  endtask

  task automatic do_start(input int b, input int l, output int s);
    @(posedge clka); #1;
    start = 1'b1; base_addr = AW'(b); len = (AW + 1)'(l); s = cyc;
    @(posedge clka); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int max, input string name);
    for (int i = 0; i < max && done_cyc.size() < n; i++) @(posedge clka);
    check(name, done_cyc.size() >= n, 1);
    repeat (2) @(posedge clka);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1);
  end

  int s, s2;
  initial begin
    repeat (3) @(posedge clka);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clka);

    // Basic latency and throughput: base 4, len 3.
    clear_logs();
    do_start(4, 3, s);
    wait_done(1, 50, "t1_done_seen");
    check("t1_ena0_cyc", ec(0), s + 1);
    check("t1_hs0_cyc", hc(0), s + 3);
    check("t1_hs1_cyc", hc(1), s + 4);
    check("t1_hs2_cyc", hc(2), s + 5);
    check("t1_d0", hd(0), 4); check("t1_d1", hd(1), 5); check("t1_d2", hd(2), 6);
    check("t1_last1", hl(1), 0); check("t1_last2", hl(2), 1);
    check("t1_done_cyc", dc(0), s + 6);

    // Address wrap.
    clear_logs();
    do_start(ML - 2, 4, s);
    wait_done(1, 50, "t2_done_seen");
    check("t2_a0", ea(0), ML - 2); check("t2_a1", ea(1), ML - 1);
    check("t2_a2", ea(2), 0);      check("t2_a3", ea(3), 1);
    check("t2_d0", hd(0), ML - 2); check("t2_d2", hd(2), 0); check("t2_d3", hd(3), 1);

    // Backpressure pattern.
    ready_mode = 1; ready_phase = 0;
    clear_logs();
    do_start(10, 8, s);
    wait_done(1, 200, "t3_done_seen");
    check("t3_count", hs_data.size(), 8);
    for (int i = 0; i < 8; i++) check("t3_data", hd(i), 10 + i);
    check("t3_last", hl(7), 1);
    ready_mode = 0;

    // len == 0, then a start pulse while busy.
    clear_logs();
    do_start(7, 0, s);
    repeat (3) @(posedge clka);
    check("t4_no_read", ena_cyc.size(), 0);
    check("t4_done_cyc", dc(0), s + 1);
    clear_logs();
    do_start(2, 3, s);
    do_start(0, 5, s2);
    wait_done(1, 50, "t5_done_seen");
    check("t5_count", hs_data.size(), 3);
    check("t5_reads", ena_cyc.size(), 3);
    check("t5_d0", hd(0), 2); check("t5_d2", hd(2), 4);

    // Reset mid-transfer.
    clear_logs();
    do_start(0, 5, s);
    for (int i = 0; i < 20 && hs_data.size() < 1; i++) @(posedge clka);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", m_valid, 0);
    check("t6_rst_busy", busy, 0);
    repeat (2) @(posedge clka);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clka);
    check("t6_after_valid", m_valid, 0);
    clear_logs();
    do_start(0, 2, s);
    wait_done(1, 50, "t6_done_seen");
    check("t6_count", hs_data.size(), 2);
    check("t6_d0", hd(0), 0); check("t6_d1", hd(1), 1);

    // Randomized traffic, including starts while busy and len == 0.
    ready_mode = 2;
    for (int t = 0; t < 40; t++) begin
      do_start($urandom_range(0, ML - 1), $urandom_range(0, 12), s);
      repeat ($urandom_range(0, 14)) @(posedge clka);
    end
    for (int i = 0; i < 1000 && (m_busy || exp_q.size() > 0); i++) @(posedge clka);
    check("rand_drained", m_busy || exp_q.size() > 0, 0);
    repeat (3) @(posedge clka);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
